// File: rtl/dmem_uart_bridge_pkg.sv
// ============================================================================
// Module      : dmem_uart_bridge_pkg
// Description : Shared constants for the data-memory / UART bridge: the
//               address map, STATUS bit positions and the TX state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_uart_bridge_pkg;

  // Address map (full 32-bit byte addresses)
  localparam logic [31:0] RAM_BASE    = 32'h1001_0000;
  localparam logic [31:0] UART_TXDATA = 32'h1001_1000;
  localparam logic [31:0] UART_STATUS = 32'h1001_1004;
  localparam logic [31:0] UART_BAUD   = 32'h1001_1008;

  // STATUS register bit positions; count occupies [ST_COUNT_LSB +: 4]
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  // Transmitter state encoding
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_uart_bridge_if.sv
// ============================================================================
// Module      : dmem_uart_bridge_if
// Description : CPU data-bus bundle. The CPU drives strobe, direction,
//               address and write data; the bridge returns read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_uart_bridge_if;
  logic        DM_CS;
  logic        ram_wena;
  logic [31:0] modified_ram_addr;
  logic [31:0] reg_data;
  logic [31:0] ram_data;

  modport master (
    output DM_CS, ram_wena, modified_ram_addr, reg_data,
    input  ram_data
  );

  modport slave (
    input  DM_CS, ram_wena, modified_ram_addr, reg_data,
    output ram_data
  );
endinterface

`default_nettype wire

// File: rtl/dmem_uart_bridge_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with combinational head output. A push is
//               taken when not full, or when full but popped in the same
//               cycle. DEPTH must be a power of two so pointers wrap freely.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push/pop keeps count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/dmem_uart_bridge.sv
// ============================================================================
// Module      : dmem_uart_bridge
// Description : Decodes the CPU data bus into a word-addressed RAM and a
//               memory-mapped 8N1 UART transmitter fed by a TX FIFO.
//               Reads are combinational; writes commit on the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_uart_bridge
  import dmem_uart_bridge_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                reset,
  dmem_uart_bridge_if.slave   bus,
  output logic                uart_tx
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  // ---------------- bus decode ----------------
  logic [31:0]     w_addr;
  logic [31:0]     w_ram_off;
  logic            w_ram_hit;
  logic [RAM_AW-1:0] w_idx;
  logic            w_wr;
  logic            w_rd;
  logic            w_push;

  assign w_addr    = bus.modified_ram_addr;
  assign w_ram_off = w_addr - RAM_BASE;
  assign w_ram_hit = (w_addr >= RAM_BASE) && (w_ram_off < 32'(4 * RAM_WORDS));
  assign w_idx     = w_ram_off[RAM_AW+1:2];
  assign w_wr      = bus.DM_CS && bus.ram_wena;
  assign w_rd      = bus.DM_CS && !bus.ram_wena;
  assign w_push    = w_wr && (w_addr == UART_TXDATA);

  // ---------------- storage and registers ----------------
  logic [31:0]   r_mem [RAM_WORDS];
  logic [15:0]   r_baud_div;
  logic          r_ovf;
  logic [7:0]    w_fifo_dout;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_pop;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr && w_ram_hit) r_mem[w_idx] <= bus.reg_data;
  end

  // Baud divisor and sticky overflow flag; divisor of 0 would stall, so store 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_div <= 16'(CLKS_PER_BIT);
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr && (w_addr == UART_BAUD))
        r_baud_div <= (bus.reg_data[15:0] == 16'd0) ? 16'd1 : bus.reg_data[15:0];
      if (w_wr && (w_addr == UART_STATUS))
        r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.reg_data[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // ---------------- TX state machine ----------------
  tx_state_t r_state, w_state_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [2:0]  r_bit, w_bit_n;
  logic [15:0] r_baud_cnt, w_baud_cnt_n;
  logic [15:0] r_bdiv_frame, w_bdiv_frame_n;
  logic        r_tx, w_tx_n;
  logic        w_bit_end;

  assign w_bit_end = (r_baud_cnt == r_bdiv_frame - 16'd1);

  // State register; the line output is registered so it never glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= TX_IDLE;
      r_shift      <= '0;
      r_bit        <= '0;
      r_baud_cnt   <= '0;
      r_bdiv_frame <= 16'(CLKS_PER_BIT);
      r_tx         <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_shift      <= w_shift_n;
      r_bit        <= w_bit_n;
      r_baud_cnt   <= w_baud_cnt_n;
      r_bdiv_frame <= w_bdiv_frame_n;
      r_tx         <= w_tx_n;
    end
  end

  // Next-state: divisor is latched per frame so BAUD writes apply next frame
  always_comb begin
    w_state_n      = r_state;
    w_shift_n      = r_shift;
    w_bit_n        = r_bit;
    w_baud_cnt_n   = r_baud_cnt + 16'd1;
    w_bdiv_frame_n = r_bdiv_frame;
    w_pop          = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_baud_cnt_n = '0;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_n      = w_fifo_dout;
          w_bdiv_frame_n = r_baud_div;
          w_bit_n        = '0;
          w_state_n      = TX_START;
        end
      end
      TX_START: if (w_bit_end) begin
        w_baud_cnt_n = '0;
        w_state_n    = TX_DATA;
      end
      TX_DATA: if (w_bit_end) begin
        w_baud_cnt_n = '0;
        w_shift_n    = {1'b0, r_shift[7:1]};
        w_bit_n      = r_bit + 3'd1;
        if (r_bit == 3'd7) w_state_n = TX_STOP;
      end
      TX_STOP: if (w_bit_end) begin
        w_baud_cnt_n = '0;
        w_state_n    = TX_IDLE;
      end
      default: w_state_n = TX_IDLE;
    endcase
    case (w_state_n)
      TX_START: w_tx_n = 1'b0;
      TX_DATA:  w_tx_n = w_shift_n[0];
      default:  w_tx_n = 1'b1;
    endcase
  end

  assign uart_tx = r_tx;

  // ---------------- read mux ----------------
  logic [31:0] w_status;
  logic [31:0] w_rdata;

  // STATUS word assembly and decoded read data (0 unless a mapped read)
  always_comb begin
    w_status                      = '0;
    w_status[ST_BUSY]             = (r_state != TX_IDLE);
    w_status[ST_FULL]             = w_full;
    w_status[ST_EMPTY]            = w_empty;
    w_status[ST_OVF]              = r_ovf;
    w_status[ST_COUNT_LSB +: 4]   = 4'(w_count);
    w_rdata = '0;
    if (w_rd) begin
      if (w_ram_hit)                   w_rdata = r_mem[w_idx];
      else if (w_addr == UART_STATUS)  w_rdata = w_status;
      else if (w_addr == UART_BAUD)    w_rdata = {16'b0, r_baud_div};
    end
  end

  assign bus.ram_data = w_rdata;
endmodule

`default_nettype wire

// File: tb/tb_dmem_uart_bridge.sv
// ============================================================================
// Module      : tb_dmem_uart_bridge
// Description : Self-checking bench: table of bus accesses, a UART frame
//               scoreboard, and hand sequences for FIFO, baud and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_uart_bridge;
  import dmem_uart_bridge_pkg::*;

  localparam int CPB = 868;

  logic clk = 1'b0;
  logic reset;
  logic uart_tx;

  always #5 clk = ~clk;

  dmem_uart_bridge_if bus();

  dmem_uart_bridge #(
    .RAM_WORDS    (1024),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] data;
    int         bdiv;
  } frame_t;

  frame_t sb[$];
  bit     mon_en     = 1'b1;
  bit     mon_busy   = 1'b0;
  int     frames_seen = 0;

  typedef struct {
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic bus_idle();
    bus.DM_CS             = 1'b0;
    bus.ram_wena          = 1'b0;
    bus.modified_ram_addr = '0;
    bus.reg_data          = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.DM_CS = 1'b1; bus.ram_wena = 1'b1;
    bus.modified_ram_addr = a; bus.reg_data = d;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.DM_CS = 1'b1; bus.ram_wena = 1'b0;
    bus.modified_ram_addr = a; bus.reg_data = '0;
    #1;
    d = bus.ram_data;
    bus_idle();
  endtask

  task automatic wait_drain(input int bound);
    int i;
    i = 0;
    while (i < bound && (sb.size() != 0 || mon_busy)) begin
      @(negedge clk);
      i++;
    end
    chk("drain_pending_frames", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Frame monitor: sample each bit mid-period using the expected divisor
  frame_t     mon_e;
  logic [9:0] mon_bits;
  int         mon_off;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_tx == 1'b0) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: line fell with no byte pending, required idle");
          mon_e = '{8'h00, 1};
        end else begin
          mon_e = sb.pop_front();
        end
        mon_off = 0;
        for (int i = 0; i < 10; i++) begin
          while (mon_off < i * mon_e.bdiv + mon_e.bdiv / 2) begin
            @(negedge clk);
            mon_off++;
          end
          mon_bits[i] = uart_tx;
        end
        while (mon_off < 10 * mon_e.bdiv - 1) begin
          @(negedge clk);
          mon_off++;
        end
        chk("frame_bits", {22'b0, mon_bits}, {22'b0, 1'b1, mon_e.data, 1'b0});
        frames_seen++;
        mon_busy = 1'b0;
      end
    end
  end

  // Watchdog bound on total run time
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] r;
  int          busy_cnt;
  bit          done;
  bit          found;
  bit          stayed;
  int          frames_before;

  initial begin
    vt[0]  = '{1'b1, 1'b1, 32'h1001_0014, 32'h1234_5678, 32'h0, "ram_wr_14"};
    vt[1]  = '{1'b1, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 32'h0, "ram_wr_10"};
    vt[2]  = '{1'b1, 1'b0, 32'h1001_0010, 32'h0, 32'hDEAD_BEEF, "ram_rd_10"};
    vt[3]  = '{1'b1, 1'b0, 32'h1001_0013, 32'h0, 32'hDEAD_BEEF, "ram_rd_13"};
    vt[4]  = '{1'b1, 1'b0, 32'h1001_0014, 32'h0, 32'h1234_5678, "ram_rd_14"};
    vt[5]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h0, 32'h0, "unmapped_rd"};
    vt[6]  = '{1'b1, 1'b1, 32'h1001_0000, 32'h0102_0304, 32'h0, "ram_wr_first"};
    vt[7]  = '{1'b1, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 32'h0, "ram_wr_last"};
    vt[8]  = '{1'b1, 1'b0, 32'h1001_0FFC, 32'h0, 32'hCAFE_F00D, "ram_rd_last"};
    vt[9]  = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h0102_0304, "ram_rd_first"};
    vt[10] = '{1'b1, 1'b0, 32'h1001_1000, 32'h0, 32'h0, "txdata_rd"};
    vt[11] = '{1'b0, 1'b0, 32'h1001_0010, 32'h0, 32'h0, "no_cs_rd"};
    vt[12] = '{1'b1, 1'b1, 32'h1001_100C, 32'h1111_1111, 32'h0, "unmapped_wr"};
    vt[13] = '{1'b1, 1'b0, 32'h1001_100C, 32'h0, 32'h0, "unmapped_rd2"};
    vt[14] = '{1'b1, 1'b1, 32'h0FFF_FFFC, 32'h2222_2222, 32'h0, "below_ram_wr"};
    vt[15] = '{1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0, 32'h0, "below_ram_rd"};
    vt[16] = '{1'b1, 1'b0, UART_STATUS, 32'h0, 32'h0000_0004, "status_reset"};
    vt[17] = '{1'b1, 1'b0, UART_BAUD, 32'h0, CPB, "baud_reset"};

    // Reset
    bus_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("tx_in_reset", {31'b0, uart_tx}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven bus accesses
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus.DM_CS = vt[i].cs; bus.ram_wena = vt[i].we;
      bus.modified_ram_addr = vt[i].addr; bus.reg_data = vt[i].wdata;
      #1;
      chk(vt[i].name, bus.ram_data, vt[i].exp);
      if (vt[i].cs && vt[i].we) begin
        @(posedge clk);
        #1;
      end
      bus_idle();
    end

    // Single frame at BAUD=4 with latency and busy-length checks
    bus_write(UART_BAUD, 32'd4);
    bus_read(UART_BAUD, r);
    chk("baud_rd_4", r, 32'd4);
    sb.push_back('{8'hA5, 4});
    bus_write(UART_TXDATA, 32'hA5);
    chk("tx_high_at_push", {31'b0, uart_tx}, 32'd1);
    @(posedge clk);
    #1;
    chk("tx_low_after_pop", {31'b0, uart_tx}, 32'd0);
    busy_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      bus_read(UART_STATUS, r);
      if (r[ST_BUSY]) busy_cnt++;
      else if (busy_cnt > 0) done = 1'b1;
    end
    chk("busy_clocks", busy_cnt, 32'd40);
    wait_drain(200);

    // FIFO fill and overflow at BAUD=100
    bus_write(UART_BAUD, 32'd100);
    frames_before = frames_seen;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back('{8'h10 + 8'(i), 100});
      bus_write(UART_TXDATA, 32'h10 + 32'(i));
    end
    bus_read(UART_STATUS, r);
    chk("status_full_ovf", r, 32'h8B);
    bus_write(UART_STATUS, 32'h0);
    bus_read(UART_STATUS, r);
    chk("status_ovf_cleared", r, 32'h83);
    wait_drain(12000);
    chk("nine_frames", frames_seen - frames_before, 32'd9);

    // Push into a full FIFO during the pop cycle
    bus_write(UART_BAUD, 32'd4);
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{8'h40 + 8'(i), 4});
      bus_write(UART_TXDATA, 32'h40 + 32'(i));
    end
    bus_read(UART_STATUS, r);
    chk("status_full_no_ovf", r, 32'h83);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      bus.DM_CS = 1'b1; bus.ram_wena = 1'b0; bus.modified_ram_addr = UART_STATUS;
      #1;
      if (!bus.ram_data[ST_BUSY]) begin
        found = 1'b1;
        chk("idle_slot_status", bus.ram_data, 32'h82);
        sb.push_back('{8'h77, 4});
        bus.ram_wena = 1'b1; bus.modified_ram_addr = UART_TXDATA; bus.reg_data = 32'h77;
        @(posedge clk);
        #1;
      end
      bus_idle();
    end
    chk("idle_slot_found", {31'b0, found}, 32'd1);
    bus_read(UART_STATUS, r);
    chk("push_pop_full", r, 32'h83);
    wait_drain(1000);

    // BAUD=0 stored as 1, then a mid-frame divisor change
    bus_write(UART_BAUD, 32'd0);
    bus_read(UART_BAUD, r);
    chk("baud_zero_as_one", r, 32'd1);
    sb.push_back('{8'h3C, 1});
    bus_write(UART_TXDATA, 32'h3C);
    wait_drain(100);
    bus_write(UART_BAUD, 32'd4);
    sb.push_back('{8'hC3, 4});
    sb.push_back('{8'h5A, 6});
    bus_write(UART_TXDATA, 32'hC3);
    bus_write(UART_TXDATA, 32'h5A);
    repeat (10) @(posedge clk);
    bus_write(UART_BAUD, 32'd6);
    wait_drain(300);

    // Asynchronous reset in the middle of a DATA bit
    bus_write(32'h1001_0100, 32'h0BAD_F00D);
    mon_en = 1'b0;
    bus_write(UART_BAUD, 32'd8);
    bus_write(UART_TXDATA, 32'h00);
    repeat (20) @(posedge clk);
    #2;
    chk("tx_low_in_data", {31'b0, uart_tx}, 32'd0);
    reset = 1'b1;
    #1;
    chk("tx_high_on_reset", {31'b0, uart_tx}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_read(UART_STATUS, r);
    chk("status_after_reset", r, 32'h04);
    bus_read(UART_BAUD, r);
    chk("baud_after_reset", r, CPB);
    bus_read(32'h1001_0100, r);
    chk("ram_kept_100", r, 32'h0BAD_F00D);
    bus_read(32'h1001_0010, r);
    chk("ram_kept_10", r, 32'hDEAD_BEEF);
    stayed = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!uart_tx) stayed = 1'b0;
    end
    chk("line_idle_after_reset", {31'b0, stayed}, 32'd1);
    mon_en = 1'b1;

    chk("frames_total", frames_seen, 32'd23);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
